// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register, IF/ID pipeline register, RUN/HALT
// control for fetches past the end of instruction memory, and a saturating
// count of valid instructions handed to decode.
module fetch_stage #(
  parameter logic [31:0] RESET_PC   = 32'h0,
  parameter int unsigned IMEM_WORDS = 65
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] instr_i,
  input  logic        stall_i,
  input  logic        flush_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic [31:0] pc_o,
  output logic [31:0] ifid_pc4_o,
  output logic [31:0] ifid_instr_o,
  output logic        ifid_valid_o,
  output logic        halted_o,
  output logic [15:0] fetch_count_o
);

  localparam int unsigned   LP_PC_W  = 32;
  localparam int unsigned   LP_CNT_W = 16;
  localparam logic [31:0]   LP_LIMIT = 32'(4 * IMEM_WORDS);

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;

  logic [LP_PC_W-1:0]   r_pc;
  logic [LP_PC_W-1:0]   r_ifid_pc4;
  logic [LP_PC_W-1:0]   r_ifid_instr;
  logic                 r_ifid_valid;
  logic [LP_CNT_W-1:0]  r_count;

  logic [LP_PC_W-1:0]   w_pc_nxt;
  logic [LP_PC_W-1:0]   w_ifid_pc4_nxt;
  logic [LP_PC_W-1:0]   w_ifid_instr_nxt;
  logic                 w_ifid_valid_nxt;
  logic [LP_CNT_W-1:0]  w_count_nxt;

  logic [LP_PC_W-1:0]   w_pc_plus4;
  logic [LP_PC_W-1:0]   w_redirect_aligned;
  logic [LP_CNT_W-1:0]  w_count_inc;
  logic                 w_past_end;
  logic                 w_unused;

  // Shared arithmetic: wrapping PC+4, word-aligned target, saturating count
  assign w_pc_plus4         = r_pc + LP_PC_W'(4);
  assign w_redirect_aligned = {redirect_pc_i[31:2], 2'b00};
  assign w_count_inc        = (r_count == 16'hFFFF) ? r_count : r_count + LP_CNT_W'(1);
  assign w_past_end         = (r_pc >= LP_LIMIT);
  assign w_unused           = ^redirect_pc_i[1:0];

  // State register
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) r_state <= ST_RUN;
    else        r_state <= w_state_nxt;
  end

  // Next-state: halt on a fetch past memory end, resume only on redirect
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_RUN:  if (!redirect_i && w_past_end) w_state_nxt = ST_HALT;
      ST_HALT: if (redirect_i)                w_state_nxt = ST_RUN;
      default: w_state_nxt = ST_RUN;
    endcase
  end

  // Output/datapath decode: redirect > past-end > flush > stall > normal fetch
  always_comb begin
    w_pc_nxt         = r_pc;
    w_ifid_pc4_nxt   = r_ifid_pc4;
    w_ifid_instr_nxt = r_ifid_instr;
    w_ifid_valid_nxt = r_ifid_valid;
    w_count_nxt      = r_count;
    case (r_state)
      ST_RUN: begin
        if (redirect_i) begin
          w_pc_nxt         = w_redirect_aligned;
          w_ifid_pc4_nxt   = '0;
          w_ifid_instr_nxt = '0;
          w_ifid_valid_nxt = 1'b0;
        end else if (w_past_end) begin
          w_ifid_pc4_nxt   = '0;
          w_ifid_instr_nxt = '0;
          w_ifid_valid_nxt = 1'b0;
        end else if (flush_i) begin
          if (!stall_i) w_pc_nxt = w_pc_plus4;
          w_ifid_pc4_nxt   = '0;
          w_ifid_instr_nxt = '0;
          w_ifid_valid_nxt = 1'b0;
        end else if (!stall_i) begin
          w_pc_nxt         = w_pc_plus4;
          w_ifid_pc4_nxt   = w_pc_plus4;
          w_ifid_instr_nxt = instr_i;
          w_ifid_valid_nxt = 1'b1;
          w_count_nxt      = w_count_inc;
        end
      end
      default: begin
        if (redirect_i) w_pc_nxt = w_redirect_aligned;
        w_ifid_pc4_nxt   = '0;
        w_ifid_instr_nxt = '0;
        w_ifid_valid_nxt = 1'b0;
      end
    endcase
  end

  // PC, IF/ID and fetch counter registers
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_pc         <= RESET_PC;
      r_ifid_pc4   <= '0;
      r_ifid_instr <= '0;
      r_ifid_valid <= 1'b0;
      r_count      <= '0;
    end else begin
      r_pc         <= w_pc_nxt;
      r_ifid_pc4   <= w_ifid_pc4_nxt;
      r_ifid_instr <= w_ifid_instr_nxt;
      r_ifid_valid <= w_ifid_valid_nxt;
      r_count      <= w_count_nxt;
    end
  end

  assign pc_o          = r_pc;
  assign ifid_pc4_o    = r_ifid_pc4;
  assign ifid_instr_o  = r_ifid_instr;
  assign ifid_valid_o  = r_ifid_valid;
  assign halted_o      = (r_state == ST_HALT);
  assign fetch_count_o = r_count;

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameters: RESET_PC, default 32'h0, PC value loaded on reset.
REQ-002 Parameters: IMEM_WORDS, default 65, instruction memory depth in words; fetch limit = 4*IMEM_WORDS bytes.
REQ-003 Ports: clk_i  in  1  single clock; all state updates on its rising edge.
REQ-004 Ports: rst_i  in  1  reset, asynchronous, active-low.
REQ-005 Ports: instr_i  in  32  instruction word returned combinationally by instruction memory for address pc_o.
REQ-006 Ports: stall_i  in  1  hazard stall; hold PC and IF/ID.
REQ-007 Ports: flush_i  in  1  squash the IF/ID register contents.
REQ-008 Ports: redirect_i  in  1  taken branch/jump; load redirect_pc_i.
REQ-009 Ports: redirect_pc_i  in  32  redirect target byte address.
REQ-010 Ports: pc_o  out  32  current PC, byte address driven to instruction memory.
REQ-011 Ports: ifid_pc4_o  out  32  registered PC+4 of fetched instruction.
REQ-012 Ports: ifid_instr_o  out  32  registered fetched instruction.
REQ-013 Ports: ifid_valid_o  out  1  IF/ID holds a real instruction.
REQ-014 Ports: halted_o  out  1  fetch halted past memory end.
REQ-015 Ports: fetch_count_o  out  16  count of valid IF/ID loads.

Function
REQ-016 pc_o SHALL equal the PC register directly, no combinational path from inputs.
REQ-017 FSM SHALL have two states, RUN and HALT; halted_o = 1 only in HALT.
REQ-018 RUN, no redirect, no stall: edge SHALL load PC <= PC+4 and IF/ID <= {PC+4, instr_i, valid 1}.
REQ-019 PC+4 SHALL wrap modulo 2^32.
REQ-020 redirect_i SHALL take priority over stall_i and flush_i: PC <= {redirect_pc_i[31:2], 2'b00}, IF/ID <= {0, 0, valid 0}.
REQ-021 stall_i without redirect SHALL hold PC, IF/ID and fetch_count_o unchanged, unless flush_i is also high.
REQ-022 flush_i without redirect SHALL load IF/ID with {0, 0, valid 0}; PC advances by 4 unless stall_i is high, in which case PC holds.
REQ-023 RUN with PC >= 4*IMEM_WORDS and no redirect SHALL at the edge go to HALT, hold PC, load IF/ID bubble (all zero, valid 0).
REQ-024 HALT SHALL hold PC and keep IF/ID as a bubble regardless of stall_i/flush_i.
REQ-025 HALT with redirect_i SHALL load the aligned target, go to RUN, keep IF/ID bubble; an out-of-range target re-enters HALT on the next edge per REQ-023.
REQ-026 fetch_count_o SHALL increment by 1 on each edge loading ifid_valid_o = 1, saturating at 16'hFFFF.
REQ-027 Instruction fetch latency SHALL be one cycle: instr_i sampled at address pc_o appears on ifid_instr_o after the next edge.

Reset
REQ-028 rst_i low SHALL immediately, independent of clk_i, set PC = RESET_PC, IF/ID all zero, ifid_valid_o = 0, fetch_count_o = 0, state RUN, halted_o = 0.
REQ-029 Reset asserted mid-operation (including HALT or during stall/redirect) SHALL abandon all state per REQ-028; first fetch follows the first edge after rst_i rises.

Verification
REQ-030 Reset release, memory word n = 32'h1000_0000+n, no stall -> pc_o 0,4,8; after edge 1 ifid_pc4_o = 4, ifid_instr_o = 32'h1000_0000, valid 1, fetch_count_o = 1.
REQ-031 At pc_o = 8 hold stall_i high 2 edges -> pc_o stays 8, ifid_pc4_o stays 8, fetch_count_o unchanged; release -> pc_o 12.
REQ-032 At pc_o = 12 pulse redirect_i, redirect_pc_i = 32'h23, stall_i = 1 same cycle -> pc_o = 32'h20, ifid_valid_o = 0, ifid_instr_o = 0, count unchanged.
REQ-033 flush_i alone at pc_o = 16 -> pc_o = 20, ifid_valid_o = 0; next edge valid 1 with ifid_pc4_o = 24.
REQ-034 Run to pc_o = 260 (IMEM_WORDS = 65) -> next edge halted_o = 1, pc_o = 260, valid 0; redirect to 0 -> RUN, halted_o = 0, pc_o = 0.
REQ-035 Drop rst_i between edges at pc_o = 40, count = 10 -> pc_o = 0, count = 0, valid 0, halted_o = 0 without a clock edge.
